// File: rtl/mem_access_arbiter.sv
// Arbiter sharing the MEM-stage data memory between the pipeline and the debug unit.
// The pipeline has priority; debug is granted on an idle cycle or forced after MAX_WAIT busy cycles.
module mem_access_arbiter #(
    parameter int LEN      = 32,
    parameter int MAX_WAIT = 4,
    parameter int NB_WAIT  = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [LEN-1:0] i_pipe_addr,
    input  logic [LEN-1:0] i_pipe_wdata,
    input  logic           i_pipe_we,
    input  logic           i_pipe_re,
    output logic [LEN-1:0] o_pipe_rdata,
    output logic           o_pipe_stall,
    input  logic           i_dbg_req,
    input  logic           i_dbg_we,
    input  logic [LEN-1:0] i_dbg_addr,
    input  logic [LEN-1:0] i_dbg_wdata,
    output logic           o_dbg_ack,
    output logic [LEN-1:0] o_dbg_rdata,
    output logic [LEN-1:0] o_mem_addr,
    output logic [LEN-1:0] o_mem_wdata,
    output logic           o_mem_wea,
    output logic           o_mem_ena,
    input  logic [LEN-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    localparam logic [NB_WAIT-1:0] WAIT_LAST = NB_WAIT'(MAX_WAIT - 1);

    state_t             state;
    logic [NB_WAIT-1:0] wait_cnt;
    logic               lat_we;
    logic [LEN-1:0]     lat_addr;
    logic [LEN-1:0]     lat_wdata;
    logic [LEN-1:0]     rdata_q;
    logic               fresh;
    logic               ack_q;
    logic               stall_q;
    logic               pipe_busy;
    logic               access;

    assign pipe_busy = i_pipe_re | i_pipe_we;
    assign access    = (state == ACCESS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            fresh     <= 1'b0;
            ack_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_dbg_req) begin
                        lat_we    <= i_dbg_we;
                        lat_addr  <= i_dbg_addr;
                        lat_wdata <= i_dbg_wdata;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // wait_cnt only counts up while below WAIT_LAST, so it cannot wrap
                    if (!pipe_busy || wait_cnt == WAIT_LAST) begin
                        state   <= ACCESS;
                        stall_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    state   <= DONE;
                    stall_q <= 1'b0;
                    ack_q   <= 1'b1;
                    fresh   <= 1'b1;
                end
                DONE: begin
                    fresh <= 1'b0;
                    if (fresh && !lat_we) begin
                        rdata_q <= i_mem_rdata;
                    end
                    if (!i_dbg_req) begin
                        state <= IDLE;
                        ack_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory read data arrives in the first DONE cycle; forward it until captured
    always_comb begin
        o_dbg_rdata = rdata_q;
        if (state == DONE && fresh && !lat_we) begin
            o_dbg_rdata = i_mem_rdata;
        end
    end

    assign o_mem_addr   = access ? lat_addr  : i_pipe_addr;
    assign o_mem_wdata  = access ? lat_wdata : i_pipe_wdata;
    assign o_mem_wea    = !i_rst && (access ? lat_we : i_pipe_we);
    assign o_mem_ena    = !i_rst && (access || pipe_busy);
    assign o_pipe_rdata = i_mem_rdata;
    assign o_pipe_stall = stall_q;
    assign o_dbg_ack    = ack_q;

endmodule
